// File: rtl/serial_sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package serial_sub_pkg;

  // Default operand width used by the top level.
  localparam int DEFAULT_WIDTH = 4;

  // Controller states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sub_state_t;

endpackage

// File: rtl/full_subtractor1.sv
// One-bit full-subtractor cell: D = A - B - Bin, borrow-out in Bout.
module full_subtractor1 (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  // A borrow is needed when A is 0 and B is 1, or when A equals B and a borrow is incoming.
  always_comb begin
    D    = A ^ B ^ Bin;
    Bout = (~A & B) | (~(A ^ B) & Bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor, LSB first, one bit per clock, behind a
// start/busy/done handshake. A single 1-bit cell is reused for every bit and
// the borrow between bits is carried in a flop.
module serial_subtractor
  import serial_sub_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] D,
  output logic             Bout,
  output logic             busy,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  sub_state_t       r_state;
  sub_state_t       w_nextState;

  logic [WIDTH-1:0] r_aSh;
  logic [WIDTH-1:0] r_bSh;
  // Holds the WIDTH-1 difference bits already produced; the last bit comes
  // straight from the cell on the final edge.
  logic [WIDTH-2:0] r_dSh;
  logic             r_borrow;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_D;
  logic             r_Bout;

  logic             w_load;
  logic             w_step;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_dFull;

  full_subtractor1 u_cell (
    .A    (r_aSh[0]),
    .B    (r_bSh[0]),
    .Bin  (r_borrow),
    .D    (w_d),
    .Bout (w_bo)
  );

  assign w_last  = (r_cnt == LAST_CNT);
  assign w_dFull = {w_d, r_dSh};
  assign D       = r_D;
  assign Bout    = r_Bout;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic and handshake outputs; start is only honoured in IDLE or DONE.
  always_comb begin
    w_nextState = r_state;
    w_load      = 1'b0;
    w_step      = 1'b0;
    busy        = 1'b0;
    done        = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_load      = 1'b1;
          w_nextState = RUN;
        end
      end
      RUN: begin
        busy   = 1'b1;
        w_step = 1'b1;
        if (w_last) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        done = 1'b1;
        if (start) begin
          w_load      = 1'b1;
          w_nextState = RUN;
        end else begin
          w_nextState = IDLE;
        end
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Datapath: capture operands on accept, shift one bit per RUN edge, publish result on the last one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_aSh    <= '0;
      r_bSh    <= '0;
      r_dSh    <= '0;
      r_borrow <= 1'b0;
      r_cnt    <= '0;
      r_D      <= '0;
      r_Bout   <= 1'b0;
    end else if (w_load) begin
      r_aSh    <= A;
      r_bSh    <= B;
      r_dSh    <= '0;
      r_borrow <= Bin;
      r_cnt    <= '0;
    end else if (w_step) begin
      r_aSh    <= {1'b0, r_aSh[WIDTH-1:1]};
      r_bSh    <= {1'b0, r_bSh[WIDTH-1:1]};
      r_dSh    <= w_dFull[WIDTH-1:1];
      r_borrow <= w_bo;
      if (w_last) begin
        r_D    <= w_dFull;
        r_Bout <= w_bo;
      end else begin
        r_cnt  <= r_cnt + 1'b1;
      end
    end
  end

endmodule
